// File: rtl/weighted_round_robin_arbitrator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_arb_pkg
// Description : Shared arbiter helpers used by the SoC arbiter family.
//               - clogb2        : floor(log2(value)), 0 for value <= 1.
//               - onehot_to_bin : binary index of a one-hot vector (0 if none).
//               - MIN_EFF_WEIGHT: a programmed weight of 0 behaves as this.
//               - arb_state_t   : ownership-lock state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_arb_pkg;

  localparam int MIN_EFF_WEIGHT = 1;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_t;

  // floor(log2(value)); clogb2(n-1)+1 is the bit count of the largest index.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // OR-reduction of set-bit indices; exact for one-hot or zero input.
  function automatic logic [31:0] onehot_to_bin(input logic [31:0] onehot);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) begin
        r = r | 32'(i);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weighted_round_robin_arbitrator_rr_mask_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_mask_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or after the one-hot priority position,
//               searching cyclically.
// Ports       : i_req   [CHN_N-1:0] request vector
//               i_prio  [CHN_N-1:0] one-hot highest-priority channel
//               o_grant [CHN_N-1:0] one-hot grant (0 when i_req = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mask_pick #(
  parameter int CHN_N = 4
) (
  input  logic [CHN_N-1:0] i_req,
  input  logic [CHN_N-1:0] i_prio,
  output logic [CHN_N-1:0] o_grant
);

  logic [2*CHN_N-1:0] w_dreq;
  logic [2*CHN_N-1:0] w_dprio;
  logic [2*CHN_N-1:0] w_dgrant;

  // Doubling the request vector makes the wrap-around search a plain
  // subtract: the borrow from (dreq - prio) clears every bit up to and
  // including the first request at/after prio, so dreq & ~diff isolates it.
  // The upper half catches requests below prio; fold both halves.
  always_comb begin
    w_dreq   = {i_req, i_req};
    w_dprio  = {{CHN_N{1'b0}}, i_prio};
    w_dgrant = w_dreq & ~(w_dreq - w_dprio);
    o_grant  = w_dgrant[CHN_N-1:0] | w_dgrant[2*CHN_N-1:CHN_N];
  end

endmodule
`default_nettype wire

// File: rtl/weighted_round_robin_arbitrator.sv
`default_nettype none
// ============================================================================
// Module      : weighted_round_robin_arbitrator
// Description : Zero-latency weighted round-robin arbiter with accept
//               handshake and optional multi-beat ownership lock.
//               A winner may take up to weight[k] consecutive accepted
//               grants before priority rotates past it.
// Ports       : clk, rst        clock, asynchronous active-high reset
//               req      [N]    per-channel request
//               req_lock [N]    keep ownership after this beat
//               weight   [N*W]  channel k weight at [k*W +: W], 0 acts as 1
//               arb_ready       consumer accepts current grant
//               grant    [N]    one-hot grant (combinational)
//               sel             binary index of grant (0 when no grant)
//               arb_valid       grant is valid
//               locked          ownership lock active (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module weighted_round_robin_arbitrator
  import soc_arb_pkg::*;
#(
  parameter int CHN_N            = 4,
  parameter int WEIGHT_WIDTH     = 4,
  parameter int LOCK_EN          = 1,
  parameter int SIMULATION_DELAY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHN_N-1:0]                req,
  input  logic [CHN_N-1:0]                req_lock,
  input  logic [CHN_N*WEIGHT_WIDTH-1:0]   weight,
  input  logic                            arb_ready,
  output logic [CHN_N-1:0]                grant,
  output logic [clogb2(CHN_N-1):0]        sel,
  output logic                            arb_valid,
  output logic                            locked
);

  localparam int SEL_W    = clogb2(CHN_N-1) + 1;
  localparam int CREDIT_W = WEIGHT_WIDTH + 1;

  // Registers update with no modelled delay; the parameter is kept so
  // existing instantiations of the arbiter family remain compatible.
  if (SIMULATION_DELAY < 0) begin : g_sim_delay_unused
  end

  arb_state_t            state_q,     state_d;
  logic [CHN_N-1:0]      prio_q,      prio_d;
  logic [SEL_W-1:0]      owner_q,     owner_d;
  logic                  owner_vld_q, owner_vld_d;
  logic [CREDIT_W-1:0]   credit_q,    credit_d;

  logic [CHN_N-1:0]        w_rr_grant;
  logic [CHN_N-1:0]        w_owner_onehot;
  logic [CHN_N-1:0]        w_grant;
  logic [SEL_W-1:0]        w_sel;
  logic                    w_valid;
  logic                    w_accept;
  logic                    w_lock_beat;
  logic [WEIGHT_WIDTH-1:0] w_cur_weight;
  logic [CREDIT_W-1:0]     w_eff_weight;
  logic [CREDIT_W-1:0]     w_next_count;

  rr_mask_pick #(
    .CHN_N (CHN_N)
  ) u_rr_mask_pick (
    .i_req   (req),
    .i_prio  (prio_q),
    .o_grant (w_rr_grant)
  );

  // Grant / valid selection
  always_comb begin
    w_owner_onehot = CHN_N'(1) << owner_q;
    if (state_q == ST_LOCKED) begin
      // Owner keeps the grant even if it drops req; valid follows its req.
      w_grant = w_owner_onehot;
      w_valid = |(req & w_owner_onehot);
    end else begin
      w_grant = w_rr_grant;
      w_valid = |req;
    end
    w_sel    = SEL_W'(onehot_to_bin(32'(w_grant)));
    w_accept = w_valid & arb_ready;
  end

  // Weight of the currently granted channel, zero mapped to the minimum.
  always_comb begin
    w_cur_weight = '0;
    for (int k = 0; k < CHN_N; k++) begin
      if (w_grant[k]) begin
        w_cur_weight = weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
    w_eff_weight = (w_cur_weight == '0) ? CREDIT_W'(MIN_EFF_WEIGHT)
                                        : {1'b0, w_cur_weight};
  end

  // Next-state: FSM, credit and priority rotation
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    credit_d    = credit_q;

    w_lock_beat  = (LOCK_EN != 0) && ((req_lock & w_grant) != '0);
    // Grants continue a run only if the same channel held the last one;
    // a whole lock sequence leaves credit untouched, so it counts once.
    w_next_count = (owner_vld_q && (owner_q == w_sel)) ? credit_q + 1'b1
                                                        : CREDIT_W'(1);

    if (w_accept) begin
      if (w_lock_beat) begin
        state_d     = ST_LOCKED;
        owner_d     = w_sel;
        owner_vld_d = 1'b1;
      end else begin
        state_d = ST_UNLOCKED;
        if (w_next_count >= w_eff_weight) begin
          prio_d      = {w_grant[CHN_N-2:0], w_grant[CHN_N-1]};
          credit_d    = '0;
          owner_vld_d = 1'b0;
        end else begin
          prio_d      = w_grant;
          credit_d    = w_next_count;
          owner_d     = w_sel;
          owner_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      prio_q      <= CHN_N'(1);
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      credit_q    <= credit_d;
    end
  end

  assign grant     = w_grant;
  assign sel       = w_sel;
  assign arb_valid = w_valid;
  assign locked    = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_weighted_round_robin_arbitrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_round_robin_arbitrator
// Description : Directed self-checking bench for the weighted round-robin
//               arbiter (4 channels, 4-bit weights, lock enabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weighted_round_robin_arbitrator;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_lock;
  logic [15:0] weight;
  logic        arb_ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        arb_valid;
  logic        locked;

  int checks;
  int failures;

  localparam logic [3:0] RR_SEQ [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [1:0] RR_SEL [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic [3:0] WT_SEQ [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
                                        4'b1000, 4'b0001, 4'b0001, 4'b0001};

  weighted_round_robin_arbitrator #(
    .CHN_N            (4),
    .WEIGHT_WIDTH     (4),
    .LOCK_EN          (1),
    .SIMULATION_DELAY (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_lock  (req_lock),
    .weight    (weight),
    .arb_ready (arb_ready),
    .grant     (grant),
    .sel       (sel),
    .arb_valid (arb_valid),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req       = '0;
    req_lock  = '0;
    weight    = 16'h1111;
    arb_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = '0;
    req_lock  = '0;
    weight    = 16'h1111;
    arb_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || arb_valid !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got grant=%b sel=%0d valid=%b locked=%b exp 0000/0/0/0",
               grant, sel, arb_valid, locked);
    end
    next_cycle();
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || arb_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant got grant=%b valid=%b exp 0001/1", grant, arb_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req       = 4'b1111;
    arb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== RR_SEQ[i] || sel !== RR_SEL[i]) begin
        failures++;
        $display("FAIL rr_seq[%0d] got grant=%b sel=%0d exp grant=%b sel=%0d",
                 i, grant, sel, RR_SEQ[i], RR_SEL[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_weight();
    apply_reset();
    weight    = 16'h1113;
    req       = 4'b1111;
    arb_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== WT_SEQ[i]) begin
        failures++;
        $display("FAIL weight_seq[%0d] got grant=%b exp %b", i, grant, WT_SEQ[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    arb_ready = 1'b1;
    req       = 4'b0010;   // accept ch1 once, prio moves to ch2
    next_cycle();
    req      = 4'b0101;
    req_lock = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_lock = 4'b0000;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100 || locked !== (i != 0)) begin
        failures++;
        $display("FAIL lock_beat[%0d] got grant=%b locked=%b exp grant=0100 locked=%b",
                 i, grant, locked, (i != 0));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_release got grant=%b locked=%b exp 0001/0", grant, locked);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    req       = 4'b0110;
    arb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || sel !== 2'd1 || arb_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d] got grant=%b sel=%0d valid=%b exp 0010/1/1",
                 i, grant, sel, arb_valid);
      end
      next_cycle();
    end
    req = 4'b0111;         // higher-priority ch0 re-steers while unlocked
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL hold_resteer got grant=%b exp 0001", grant);
    end
    next_cycle();
    req       = 4'b0110;
    arb_ready = 1'b1;
    next_cycle();          // accept ch1, prio -> ch2
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL hold_advance got grant=%b exp 0100", grant);
    end
  endtask

  task automatic test_single_ch3();
    apply_reset();
    weight    = 16'h2111;
    req       = 4'b1000;
    arb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL ch3_first got grant=%b exp 1000", grant);
    end
    next_cycle();          // 1st accept: credit 1, prio stays ch3
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL ch3_second got grant=%b exp 1000", grant);
    end
    next_cycle();          // 2nd accept: prio wraps to ch0
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL ch3_wrap got grant=%b exp 0001", grant);
    end
    apply_reset();
    weight    = 16'h0111;  // weight3 = 0 acts as 1
    req       = 4'b1000;
    arb_ready = 1'b1;
    next_cycle();
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL ch3_zero_weight got grant=%b exp 0001", grant);
    end
  endtask

  task automatic test_lock_reset();
    apply_reset();
    req       = 4'b0010;
    req_lock  = 4'b0010;
    arb_ready = 1'b1;
    next_cycle();
    req = 4'b1101;         // owner ch1 drops req
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || arb_valid !== 1'b0 || locked !== 1'b1) begin
        failures++;
        $display("FAIL lock_drop[%0d] got grant=%b valid=%b locked=%b exp 0010/0/1",
                 i, grant, arb_valid, locked);
      end
      next_cycle();
    end
    #2;
    rst = 1'b1;            // asynchronous, mid-cycle
    #1;
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got locked=%b exp 0", locked);
    end
    rst      = 1'b0;
    req      = 4'b1111;
    req_lock = 4'b0000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || locked !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got grant=%b locked=%b exp 0001/0", grant, locked);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_weight();
    test_lock();
    test_hold();
    test_single_ch3();
    test_lock_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
